// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
// Contents:
//   FETCH_XLEN        native PC / instruction width of fetch_entry_t
//   RESET_PC_DEFAULT  default first fetch address after reset
//   fetch_state_e     PC sequencer states (RUN fetching, HALT parked on a misaligned PC)
//   fetch_entry_t     one buffered fetch result {pc, ins, misalign}
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0040;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] ins;
        logic                  misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake bundle
// Signals:
//   id_valid     queue head valid (fetch -> decode)
//   id_ready     decode accepts the head this cycle (decode -> fetch)
//   id_pc        head PC
//   id_ins       head instruction, 0 for misaligned entries
//   id_misalign  head PC has nonzero low two bits
// Modports: master = fetch side, slave = decode side.
interface fetch_queue_if #(
    parameter int XLEN = 32
) ();

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_ins;
    logic            id_misalign;

    modport master (
        output id_valid,
        output id_pc,
        output id_ins,
        output id_misalign,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_pc,
        input  id_ins,
        input  id_misalign,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
// Parameters:
//   DEPTH       entry count, power of two, >= 2
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       empties the FIFO; overrides push and pop in the same cycle
//   push        write push_entry at the tail
//   push_entry  entry to write
//   pop         drop the head
//   head        current head entry (meaningful when !empty)
//   count       number of stored entries, 0..DEPTH
//   full/empty  occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the slot being vacated is the one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head is only consumed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with decoupling prefetch queue
// Parameters:
//   XLEN      PC and instruction width
//   RESET_PC  first fetch address after reset
//   DEPTH     queue entries (power of two, >= 2; >= 3 for one entry per cycle)
//   IMEM_AW   imem word-address width
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   redirect_valid   taken jump/branch: flush queue and in-flight read, refetch
//   redirect_target  new PC when redirect_valid
//   imem_req         imem read strobe
//   imem_addr        imem word address, pc[IMEM_AW+1:2]
//   imem_rdata       imem read data, valid the cycle after imem_req
//   id               decode handshake (fetch_queue_if master)
//   fetch_halted     fetch parked on a misaligned PC until the next redirect
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter int              IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    fetch_queue_if.master      id,
    output logic               fetch_halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Legacy-compatible encoding, identical to fetch_state_e.
    localparam logic [0:0] S_RUN  = 1'(FETCH_RUN);
    localparam logic [0:0] S_HALT = 1'(FETCH_HALT);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] issue_pc;
    logic [0:0]      state;
    logic            inflight;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    logic [CW:0]     occupancy;
    logic            has_credit;
    logic            pc_misaligned;
    logic            running;
    logic            issue;
    logic            resp_push;
    logic            mis_push;
    logic            push;
    logic            pop;

    // A credit reserves a queue slot for every read still in flight, so a
    // response can always be pushed. The check uses the registered count, so
    // a pop only frees a credit from the following cycle.
    assign occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign has_credit    = !fifo_full && (occupancy < (CW+1)'(DEPTH));
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign running       = (state == S_RUN);

    // rst_n gates the strobe so it drops together with the async reset.
    assign issue = rst_n && running && !pc_misaligned && has_credit && !redirect_valid;

    // A response arriving in a redirect cycle belongs to the old stream.
    assign resp_push = inflight && !redirect_valid;

    // A misaligned PC never reaches imem; it becomes a marker entry for decode.
    // inflight can only be set after an aligned issue, so this never collides
    // with a response push; the guard keeps it that way by construction.
    assign mis_push = running && pc_misaligned && has_credit && !inflight && !redirect_valid;

    assign push = resp_push || mis_push;

    always_comb begin
        push_entry = '0;
        if (resp_push) begin
            push_entry.pc  = issue_pc;
            push_entry.ins = imem_rdata;
        end else if (mis_push) begin
            push_entry.pc       = pc;
            push_entry.misalign = 1'b1;
        end
    end

    // A pop coinciding with a redirect is discarded; the flush wins.
    assign pop = id.id_valid && id.id_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign imem_req  = issue;
    assign imem_addr = pc[IMEM_AW+1:2];

    // Head fields read as zero while empty so stale storage never leaks out.
    assign id.id_valid    = !fifo_empty;
    assign id.id_pc       = fifo_empty ? '0   : fifo_head.pc;
    assign id.id_ins      = fifo_empty ? '0   : fifo_head.ins;
    assign id.id_misalign = fifo_empty ? 1'b0 : fifo_head.misalign;

    assign fetch_halted = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            issue_pc <= '0;
            state    <= S_RUN;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_target;
            state    <= S_RUN;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issue_pc <= pc;
                pc       <= pc + XLEN'(4);
            end
            if (mis_push) begin
                state <= S_HALT;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int IMEM_AW = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mis;
    } tb_ent_t;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        fetch_halted;

    fetch_queue_if #(.XLEN(32)) id_bus ();

    fetch_queue #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0040),
        .DEPTH    (DEPTH),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .id              (id_bus),
        .fetch_halted    (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous imem: returns the byte address of the word; garbage when idle.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? {22'b0, imem_addr, 2'b00} : 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: PC, halt flag, outstanding read, and queue contents.
    tb_ent_t     mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_inf;
    logic [31:0] m_inf_pc;

    // Samples taken at the last compare point.
    logic        s_req;
    logic [7:0]  s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_ins;
    logic        s_mis;
    logic        s_halt;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] exp_ins(logic [31:0] pc);
        return {22'b0, pc[IMEM_AW+1:2], 2'b00};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_pc   = 32'h0000_0040;
        m_halt = 1'b0;
        m_inf  = 1'b0;
        cyc    = 0;
    endfunction

    function automatic bit model_req(bit rv);
        int occ;
        occ = mq.size() + (m_inf ? 1 : 0);
        return !m_halt && (m_pc[1:0] == 2'b00) && (occ < DEPTH) && !rv;
    endfunction

    function automatic void compare_model(bit rv);
        bit exp_req;
        exp_req = model_req(rv);
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", 32'(s_addr), 32'(m_pc[IMEM_AW+1:2]));
        chk("id_valid", 32'(s_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("id_pc", s_pc, mq[0].pc);
            chk("id_ins", s_ins, mq[0].ins);
            chk("id_misalign", 32'(s_mis), 32'(mq[0].mis));
        end
        chk("fetch_halted", 32'(s_halt), 32'(m_halt));
    endfunction

    function automatic void model_step(bit rv, logic [31:0] tgt, bit rdy);
        bit req;
        int occ;
        occ = mq.size() + (m_inf ? 1 : 0);
        req = model_req(rv);
        if (rv) begin
            mq.delete();
            m_inf  = 1'b0;
            m_pc   = tgt;
            m_halt = 1'b0;
            return;
        end
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (m_inf) mq.push_back('{pc: m_inf_pc, ins: exp_ins(m_inf_pc), mis: 1'b0});
        if (!m_halt && m_pc[1:0] != 2'b00 && occ < DEPTH) begin
            mq.push_back('{pc: m_pc, ins: 32'h0, mis: 1'b1});
            m_halt = 1'b1;
        end
        if (mq.size() > DEPTH) chk("model_overflow", 32'(mq.size()), 32'(DEPTH));
        m_inf = req;
        if (req) begin
            m_inf_pc = m_pc;
            m_pc     = m_pc + 32'd4;
        end
    endfunction

    task automatic run_cycle(input bit rv, input logic [31:0] tgt, input bit rdy);
        @(negedge clk);
        redirect_valid  = rv;
        redirect_target = tgt;
        id_bus.id_ready = rdy;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = id_bus.id_valid;
        s_pc    = id_bus.id_pc;
        s_ins   = id_bus.id_ins;
        s_mis   = id_bus.id_misalign;
        s_halt  = fetch_halted;
        compare_model(rv);
        model_step(rv, tgt, rdy);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_id_valid"}, 32'(id_bus.id_valid), 32'h0);
        chk({tag, "_id_pc"}, id_bus.id_pc, 32'h0);
        chk({tag, "_id_ins"}, id_bus.id_ins, 32'h0);
        chk({tag, "_id_misalign"}, 32'(id_bus.id_misalign), 32'h0);
        chk({tag, "_halted"}, 32'(fetch_halted), 32'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_restart(input string tag);
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                chk({tag, "_first_req"}, 32'(s_req), 32'h1);
                chk({tag, "_first_addr"}, 32'(s_addr), 32'h10);
                chk({tag, "_no_valid_c0"}, 32'(s_valid), 32'h0);
            end
            if (i == 1) chk({tag, "_no_valid_c1"}, 32'(s_valid), 32'h0);
            if (i == 2) begin
                chk({tag, "_valid_c2"}, 32'(s_valid), 32'h1);
                chk({tag, "_pc_c2"}, s_pc, 32'h40);
                chk({tag, "_ins_c2"}, s_ins, 32'h40);
            end
            if (i == 5) chk({tag, "_pc_c5"}, s_pc, 32'h4C);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        id_bus.id_ready = 1'b0;
        model_reset();

        // Reset state, then streaming with decode always ready.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();
        check_restart("start");
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b1);

        // Back-pressure: queue fills to DEPTH, requests stop, resume after a pop.
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b0);
        chk("stall_req_off", 32'(s_req), 32'h0);
        chk("stall_valid", 32'(s_valid), 32'h1);
        chk("stall_buffered", 32'(mq.size()), 32'(DEPTH));
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1);
            if (i == 0) chk("resume_not_yet", 32'(s_req), 32'h0);
            if (i == 1) chk("resume_req", 32'(s_req), 32'h1);
        end

        // Redirect to 0x100 with three entries buffered and one read in flight.
        for (int i = 0; i < 8; i++) begin
            if (mq.size() == 3 && m_inf) break;
            run_cycle(1'b0, 32'h0, 1'b0);
        end
        chk("pre_redirect_state", {30'b0, mq.size() == 3, m_inf}, 32'h3);
        run_cycle(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                chk("redir_r1_valid", 32'(s_valid), 32'h0);
                chk("redir_r1_req", 32'(s_req), 32'h1);
                chk("redir_r1_addr", 32'(s_addr), 32'h40);
            end
            if (i == 1) chk("redir_r2_valid", 32'(s_valid), 32'h0);
            if (i == 2) begin
                chk("redir_r3_valid", 32'(s_valid), 32'h1);
                chk("redir_r3_pc", s_pc, 32'h100);
            end
        end

        // Misaligned redirect: one marker entry, then parked until redirected.
        run_cycle(1'b1, 32'h102, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 32'h0, 1'($urandom_range(0, 1)));
            chk("halt_no_req", 32'(s_req), 32'h0);
            if (i == 1) begin
                chk("mis_valid", 32'(s_valid), 32'h1);
                chk("mis_pc", s_pc, 32'h102);
                chk("mis_flag", 32'(s_mis), 32'h1);
                chk("mis_ins", s_ins, 32'h0);
                chk("mis_halted", 32'(s_halt), 32'h1);
            end
        end
        run_cycle(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                chk("unhalt_req", 32'(s_req), 32'h1);
                chk("unhalt_addr", 32'(s_addr), 32'h80);
                chk("unhalt_flag", 32'(s_halt), 32'h0);
            end
        end

        // Redirect coinciding with a pop of a full queue.
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0);
        chk("full_before_redirect", 32'(mq.size()), 32'(DEPTH));
        run_cycle(1'b1, 32'h300, 1'b1);
        run_cycle(1'b0, 32'h0, 1'b1);
        chk("flush_pop_empty", 32'(s_valid), 32'h0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 32'h0, 1'b1);

        // Randomised traffic: back-pressure, redirects, misaligned and wrapping targets.
        for (int i = 0; i < 800; i++) begin
            bit          rv;
            bit          rdy;
            logic [31:0] tgt;
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom & 32'hFFFF_FFFC;
                1:       tgt = ($urandom & 32'hFFFF_FFFC) | 32'(($urandom_range(1, 3)));
                2:       tgt = 32'hFFFF_FFF0;
                default: tgt = $urandom_range(0, 255) * 4;
            endcase
            run_cycle(rv, tgt, rdy);
        end

        // Mid-stream asynchronous reset with data still buffered and in flight.
        run_cycle(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        release_reset();
        check_restart("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
